// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way
// Two-way set-associative write-back data cache controller. It holds the
// tag, valid, dirty and LRU state plus the data array and serves one CPU
// request at a time. A miss writes a dirty victim back one word at a time,
// then refills the line one word at a time over a req/ack memory port, and
// finishes with a second lookup that now hits.
module cache_ctrl_2way #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int SETS   = 4,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WRD_W = $clog2(WORDS);
    localparam int TAG_W = ADDR_W - IDX_W - WRD_W - 2;
    localparam int LINE_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_REFILL    = 3'd3,
        ST_RESPOND   = 3'd4
    } state_t;

    state_t              state_r;
    logic                req_we_r;
    logic [LINE_W-1:0]   req_addr_r;     // word address; byte select dropped
    logic [DATA_W-1:0]   req_wdata_r;
    logic                first_lookup_r; // still on the first lookup of this request
    logic                victim_r;
    logic [WRD_W-1:0]    cnt_r;

    logic [TAG_W-1:0]    tag_r   [2][SETS];
    logic [SETS-1:0]     valid_r [2];
    logic [SETS-1:0]     dirty_r [2];
    logic [SETS-1:0]     lru_r;          // way to evict next in each set
    logic [DATA_W-1:0]   data_r  [2][SETS][WORDS];

    logic                resp_valid_r;
    logic [DATA_W-1:0]   resp_rdata_r;
    logic                resp_hit_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;

    logic [TAG_W-1:0]    req_tag_s;
    logic [IDX_W-1:0]    req_idx_s;
    logic [WRD_W-1:0]    req_word_s;
    logic                hit0_s;
    logic                hit1_s;
    logic                hit_s;
    logic                hit_way_s;
    logic                victim_s;
    logic                victim_dirty_s;
    logic                last_word_s;
    logic [WRD_W-1:0]    cnt_nxt_s;
    logic [DATA_W-1:0]   rd_hit_s;
    logic [DATA_W-1:0]   victim_word0_s;
    logic [DATA_W-1:0]   victim_word_nxt_s;
    logic                byte_sel_unused_s;

    assign req_tag_s  = req_addr_r[LINE_W-1 -: TAG_W];
    assign req_idx_s  = req_addr_r[WRD_W +: IDX_W];
    assign req_word_s = req_addr_r[0 +: WRD_W];

    // Byte-select bits of the CPU address have no meaning for a word cache.
    assign byte_sel_unused_s = ^cpu_addr[1:0];

    // Lookup, victim selection and burst counter decode
    always_comb begin
        hit0_s            = 1'b0;
        hit1_s            = 1'b0;
        hit_s             = 1'b0;
        hit_way_s         = 1'b0;
        victim_s          = 1'b0;
        victim_dirty_s    = 1'b0;
        last_word_s       = 1'b0;
        cnt_nxt_s         = cnt_r + {{(WRD_W-1){1'b0}}, 1'b1};
        rd_hit_s          = {DATA_W{1'b0}};
        victim_word0_s    = {DATA_W{1'b0}};
        victim_word_nxt_s = {DATA_W{1'b0}};

        hit0_s    = valid_r[0][req_idx_s] && (tag_r[0][req_idx_s] == req_tag_s);
        hit1_s    = valid_r[1][req_idx_s] && (tag_r[1][req_idx_s] == req_tag_s);
        hit_s     = hit0_s || hit1_s;
        hit_way_s = hit1_s;
        rd_hit_s  = data_r[hit_way_s][req_idx_s][req_word_s];

        // An empty way is always preferred over evicting live data.
        if (!valid_r[0][req_idx_s]) begin
            victim_s = 1'b0;
        end else if (!valid_r[1][req_idx_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[req_idx_s];
        end

        victim_dirty_s    = valid_r[victim_s][req_idx_s] && dirty_r[victim_s][req_idx_s];
        victim_word0_s    = data_r[victim_s][req_idx_s][{WRD_W{1'b0}}];
        victim_word_nxt_s = data_r[victim_r][req_idx_s][cnt_nxt_s];

        if (cnt_r == WRD_W'(WORDS - 1)) begin
            last_word_s = 1'b1;
        end else begin
            last_word_s = 1'b0;
        end
    end

    // Controller FSM with cache state, response and memory-port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            req_we_r       <= 1'b0;
            req_addr_r     <= {LINE_W{1'b0}};
            req_wdata_r    <= {DATA_W{1'b0}};
            first_lookup_r <= 1'b0;
            victim_r       <= 1'b0;
            cnt_r          <= {WRD_W{1'b0}};
            lru_r          <= {SETS{1'b0}};
            for (int w = 0; w < 2; w++) begin
                valid_r[w] <= {SETS{1'b0}};
                dirty_r[w] <= {SETS{1'b0}};
                for (int s = 0; s < SETS; s++) begin
                    tag_r[w][s] <= {TAG_W{1'b0}};
                end
            end
            resp_valid_r   <= 1'b0;
            resp_rdata_r   <= {DATA_W{1'b0}};
            resp_hit_r     <= 1'b0;
            mem_req_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_wdata_r    <= {DATA_W{1'b0}};
        end else begin
            resp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cpu_valid) begin
                        req_we_r       <= cpu_we;
                        req_addr_r     <= cpu_addr[ADDR_W-1:2];
                        req_wdata_r    <= cpu_wdata;
                        first_lookup_r <= 1'b1;
                        state_r        <= ST_LOOKUP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_LOOKUP: begin
                    first_lookup_r <= 1'b0;
                    if (hit_s) begin
                        if (req_we_r) begin
                            dirty_r[hit_way_s][req_idx_s] <= 1'b1;
                            resp_rdata_r <= req_wdata_r;
                        end else begin
                            resp_rdata_r <= rd_hit_s;
                        end
                        lru_r[req_idx_s] <= ~hit_way_s;
                        // Only a hit on the very first lookup counts as a hit.
                        resp_hit_r   <= first_lookup_r;
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESPOND;
                    end else begin
                        victim_r  <= victim_s;
                        cnt_r     <= {WRD_W{1'b0}};
                        mem_req_r <= 1'b1;
                        if (victim_dirty_s) begin
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= {tag_r[victim_s][req_idx_s], req_idx_s, {WRD_W{1'b0}}, 2'b00};
                            mem_wdata_r <= victim_word0_s;
                            state_r     <= ST_WRITEBACK;
                        end else begin
                            mem_we_r   <= 1'b0;
                            mem_addr_r <= {req_tag_s, req_idx_s, {WRD_W{1'b0}}, 2'b00};
                            state_r    <= ST_REFILL;
                        end
                    end
                end

                ST_WRITEBACK: begin
                    if (mem_ack) begin
                        if (last_word_s) begin
                            // Flow straight into the refill with mem_req held high.
                            cnt_r      <= {WRD_W{1'b0}};
                            mem_we_r   <= 1'b0;
                            mem_addr_r <= {req_tag_s, req_idx_s, {WRD_W{1'b0}}, 2'b00};
                            state_r    <= ST_REFILL;
                        end else begin
                            cnt_r       <= cnt_nxt_s;
                            mem_addr_r  <= {tag_r[victim_r][req_idx_s], req_idx_s, cnt_nxt_s, 2'b00};
                            mem_wdata_r <= victim_word_nxt_s;
                            state_r     <= ST_WRITEBACK;
                        end
                    end else begin
                        state_r <= ST_WRITEBACK;
                    end
                end

                ST_REFILL: begin
                    if (mem_ack) begin
                        if (last_word_s) begin
                            mem_req_r                    <= 1'b0;
                            cnt_r                        <= {WRD_W{1'b0}};
                            valid_r[victim_r][req_idx_s] <= 1'b1;
                            dirty_r[victim_r][req_idx_s] <= 1'b0;
                            tag_r[victim_r][req_idx_s]   <= req_tag_s;
                            state_r                      <= ST_LOOKUP;
                        end else begin
                            cnt_r      <= cnt_nxt_s;
                            mem_addr_r <= {req_tag_s, req_idx_s, cnt_nxt_s, 2'b00};
                            state_r    <= ST_REFILL;
                        end
                    end else begin
                        state_r <= ST_REFILL;
                    end
                end

                ST_RESPOND: begin
                    state_r <= ST_IDLE;
                end

                default: begin
                    mem_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Data array write port: store hits and refill words; never reset
    always_ff @(posedge clk) begin
        if ((state_r == ST_LOOKUP) && hit_s && req_we_r) begin
            data_r[hit_way_s][req_idx_s][req_word_s] <= req_wdata_r;
        end else if ((state_r == ST_REFILL) && mem_ack) begin
            data_r[victim_r][req_idx_s][cnt_r] <= mem_rdata;
        end
    end

    assign cpu_ready  = (state_r == ST_IDLE);
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_hit   = resp_hit_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule
